bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_if.sv | 23 ++
 rtl/bit_serializer.sv | 116 +++++++++++
 2 files changed

// File: rtl/bit_serializer_if.sv
// Parallel-word input and serial-bit output bundle of the bit serializer.
interface bit_serializer_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         en;
    logic         sout;
    logic         sout_valid;
    logic         word_done;
    logic         busy;

    modport master (
        output din, din_valid, en,
        input  din_ready, sout, sout_valid, word_done, busy
    );

    modport slave (
        input  din, din_valid, en,
        output din_ready, sout, sout_valid, word_done, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Serializes W-bit words through a 2-entry FIFO into a registered bit stream,
// with bit-advance stall, back-to-back words and an end-of-word pulse.
module bit_serializer #(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_VAL  = 1'b0
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);
    localparam int unsigned IW = (W > 2) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_d;
    logic [W-1:0]  fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic [W-1:0]  sreg;
    logic [IW-1:0] idx;
    logic          sout_q, word_done_q;
    logic          push_c, pop_c, load_c, adv_c, retire_c;
    logic [W-1:0]  head;

    // Bit of a word presented at position i of the serial order.
    function automatic logic bit_at(input logic [W-1:0] word, input logic [IW-1:0] i);
        logic [W-1:0] sh;
        if (MSB_FIRST) begin
            sh = word << i;
            return sh[W-1];
        end
        sh = word >> i;
        return sh[0];
    endfunction

    assign head           = fifo_mem[rd_ptr];
    assign bus.din_ready  = rst && (count != 2'd2);
    assign push_c         = bus.din_valid && bus.din_ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = (state == SHIFT) && bus.en;
    assign bus.word_done  = word_done_q;
    assign bus.busy       = (state == SHIFT) || (count != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next state plus the datapath strobes for this edge.
    always_comb begin
        state_d  = state;
        pop_c    = 1'b0;
        load_c   = 1'b0;
        adv_c    = 1'b0;
        retire_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && (count != 2'd0)) begin
                    pop_c   = 1'b1;
                    load_c  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    if (idx == LAST_IDX) begin
                        retire_c = 1'b1;
                        if (count != 2'd0) begin
                            pop_c  = 1'b1;
                            load_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        adv_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage only; occupancy is tracked by count/pointers under reset.
    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= bus.din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            sreg        <= '0;
            idx         <= '0;
            sout_q      <= IDLE_VAL;
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= retire_c;
            if (push_c) wr_ptr <= ~wr_ptr;
            if (pop_c)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_c} - {1'b0, pop_c};
            if (load_c) begin
                sreg   <= head;
                idx    <= '0;
                sout_q <= bit_at(head, IW'(0));
            end else if (adv_c) begin
                idx    <= idx + 1'b1;
                sout_q <= bit_at(sreg, idx + 1'b1);
            end else if (retire_c) begin
                sout_q <= IDLE_VAL;
            end
        end
    end
endmodule
